// File: rtl/ddr_wr_arbiter_pkg.sv
// ddr_wr_arbiter_pkg: shared video DDR geometry, burst sizing and arbiter state encoding
package ddr_wr_arbiter_pkg;
  localparam int DQ_WIDTH = 32;
  localparam int DW = DQ_WIDTH * 8;
  localparam int CH_NUM = 4;
  localparam int BURST_LEN = 16;
  localparam int ADDR_WIDTH = 28;
  localparam logic [ADDR_WIDTH-1:0] FRAME_BASE = 28'h000_0000;
  localparam logic [ADDR_WIDTH-1:0] CH_STRIDE = 28'h002_0000;
  localparam int FRAME_BYTES = 115200;
  localparam int OFF_W = 17;
  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;
  function automatic logic [OFF_W-1:0] next_off(input logic [OFF_W-1:0] o);
    logic [OFF_W:0] n;
    n = {1'b0, o} + (OFF_W+1)'(BURST_LEN * DQ_WIDTH);
    return (n >= (OFF_W+1)'(FRAME_BYTES)) ? '0 : n[OFF_W-1:0];
  endfunction
endpackage

// File: rtl/ddr_wr_arbiter_skid.sv
// axi_skid_buf_2: two-entry skid buffer between the FIFO read port and the AXI W channel
// ports: clk, rst (async), in_valid/in_data push, out_valid/out_data/out_ready pop, occ = entries held
module axi_skid_buf_2 #(parameter int W = 256) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready,
  output logic [1:0]   occ
);
  logic [W-1:0] d1;
  logic pop;
  assign out_valid = occ != 2'd0;
  assign pop = out_valid && out_ready;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      occ <= 2'd0;
      out_data <= '0;
      d1 <= '0;
    end else begin
      occ <= occ + {1'b0, in_valid} - {1'b0, pop};
      if (in_valid && (occ == 2'd0 || (occ == 2'd1 && pop))) out_data <= in_data;
      else if (pop && occ == 2'd2) out_data <= d1;
      if (in_valid && ((occ == 2'd1 && !pop) || (occ == 2'd2 && pop))) d1 <= in_data;
    end
endmodule

// File: rtl/ddr_wr_arbiter.sv
// ddr_wr_arbiter: round-robin 4-channel sampler-FIFO to DDR AXI write-burst arbiter
// ports: clk, rst (async); ch_ready/ch_trans_id/ch_frame_start/ch_rd_data in, ch_rd_en out; AXI AW, W, B write channels; wr_err pulse
module ddr_wr_arbiter import ddr_wr_arbiter_pkg::*; (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [CH_NUM-1:0]      ch_ready,
  input  logic [4*CH_NUM-1:0]    ch_trans_id,
  input  logic [CH_NUM-1:0]      ch_frame_start,
  input  logic [CH_NUM*DW-1:0]   ch_rd_data,
  output logic [CH_NUM-1:0]      ch_rd_en,
  output logic [ADDR_WIDTH-1:0]  awaddr,
  output logic [3:0]             awid,
  output logic [7:0]             awlen,
  output logic                   awvalid,
  input  logic                   awready,
  output logic [DW-1:0]          wdata,
  output logic [DW/8-1:0]        wstrb,
  output logic                   wlast,
  output logic                   wvalid,
  input  logic                   wready,
  input  logic                   bvalid,
  output logic                   bready,
  input  logic [1:0]             bresp,
  output logic                   wr_err
);
  state_t state;
  logic [1:0] grant, last_grant, sel, occ;
  logic found, inflight, rd_en, pop;
  logic [4:0] rd_cnt;
  logic [3:0] beat;
  logic [OFF_W-1:0] offset [CH_NUM];
  logic [CH_NUM-1:0] pend;
  always_comb begin
    sel = last_grant;
    found = 1'b0;
    for (int k = 3; k >= 0; k--)
      if (ch_ready[last_grant + 2'(k + 1)]) begin
        sel = last_grant + 2'(k + 1);
        found = 1'b1;
      end
  end
  assign pop = wvalid && wready;
  // a beat leaving this cycle frees its slot, so reads stay back-to-back under full throughput
  assign rd_en = state == DATA && rd_cnt < 5'(BURST_LEN) && ({1'b0, occ} + {2'b0, inflight} - {2'b0, pop}) < 3'd2;
  assign ch_rd_en = CH_NUM'(rd_en) << grant;
  assign wlast = wvalid && beat == 4'(BURST_LEN - 1);
  assign awlen = 8'(BURST_LEN - 1);
  assign wstrb = '1;
  axi_skid_buf_2 #(.W(DW)) u_skid (
    .clk(clk), .rst(rst), .in_valid(inflight), .in_data(ch_rd_data[DW*grant +: DW]),
    .out_valid(wvalid), .out_data(wdata), .out_ready(wready), .occ(occ)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      grant <= 2'd0;
      last_grant <= 2'd3;
      awaddr <= '0;
      awid <= '0;
      awvalid <= 1'b0;
      bready <= 1'b0;
      wr_err <= 1'b0;
      rd_cnt <= '0;
      beat <= '0;
      inflight <= 1'b0;
      pend <= '0;
      for (int i = 0; i < CH_NUM; i++) offset[i] <= '0;
    end else begin
      wr_err <= 1'b0;
      inflight <= rd_en;
      rd_cnt <= rd_cnt + 5'(rd_en);
      beat <= beat + 4'(pop);
      // a frame start on the busy channel is deferred to its response so the current burst stays in place
      for (int i = 0; i < CH_NUM; i++)
        if (ch_frame_start[i]) begin
          if (state != IDLE && grant == 2'(i)) pend[i] <= 1'b1;
          else offset[i] <= '0;
        end
      case (state)
        IDLE: if (found) begin
          grant <= sel;
          awid <= ch_trans_id[4*sel +: 4];
          awaddr <= FRAME_BASE + ADDR_WIDTH'(sel) * CH_STRIDE + ADDR_WIDTH'(ch_frame_start[sel] ? '0 : offset[sel]);
          awvalid <= 1'b1;
          rd_cnt <= '0;
          beat <= '0;
          state <= ADDR;
        end
        ADDR: if (awready) begin
          awvalid <= 1'b0;
          state <= DATA;
        end
        DATA: if (pop && wlast) begin
          bready <= 1'b1;
          state <= RESP;
        end
        RESP: if (bvalid) begin
          bready <= 1'b0;
          last_grant <= grant;
          wr_err <= bresp != 2'b00;
          pend[grant] <= 1'b0;
          offset[grant] <= (pend[grant] || ch_frame_start[grant]) ? '0 : next_off(offset[grant]);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_ddr_wr_arbiter.sv
// tb_ddr_wr_arbiter: directed bench for ddr_wr_arbiter with a FIFO model and an AXI slave driven from tasks
module tb_ddr_wr_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic [3:0] ch_ready, ch_frame_start, ch_rd_en, awid;
  logic [15:0] ch_trans_id;
  logic [1023:0] ch_rd_data = '0;
  logic [27:0] awaddr;
  logic [7:0] awlen;
  logic awvalid, awready, wlast, wvalid, wready, bvalid, bready, wr_err;
  logic [255:0] wdata;
  logic [31:0] wstrb;
  logic [1:0] bresp;
  int vec = 0, errs = 0;
  int fifo_cnt [4];
  int rd_tot [4];
  int exp_n [4];

  ddr_wr_arbiter dut (
    .clk(clk), .rst(rst), .ch_ready(ch_ready), .ch_trans_id(ch_trans_id),
    .ch_frame_start(ch_frame_start), .ch_rd_data(ch_rd_data), .ch_rd_en(ch_rd_en),
    .awaddr(awaddr), .awid(awid), .awlen(awlen), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready), .bresp(bresp), .wr_err(wr_err)
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] word(input int c, input int n);
    logic [7:0] cb;
    logic [15:0] nb;
    cb = c[7:0];
    nb = n[15:0];
    return {8{cb, 8'hA5, nb}};
  endfunction

  // sampler FIFO: word is presented the cycle after its read strobe
  always @(posedge clk)
    for (int c = 0; c < 4; c++)
      if (ch_rd_en[c]) begin
        ch_rd_data[256*c +: 256] <= word(c, fifo_cnt[c]);
        fifo_cnt[c] <= fifo_cnt[c] + 1;
      end

  always @(negedge clk)
    for (int c = 0; c < 4; c++)
      if (ch_rd_en[c]) rd_tot[c]++;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    vec++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic aw_phase(input logic [27:0] exp_addr, input logic [3:0] exp_id);
    int cyc = 0;
    @(negedge clk);
    while (!awvalid && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("awvalid", awvalid, 1'b1);
    chk("awaddr", awaddr, exp_addr);
    chk("awid", awid, exp_id);
    awready = 1'b1;
    @(posedge clk);
    #1 awready = 1'b0;
    chk("awvalid_drop", awvalid, 1'b0);
  endtask

  task automatic w_phase(input int ch, input bit stall, input logic [3:0] fs_mask);
    int n = 0, cyc = 0, first = 0, last = 0, other = 0;
    int base [4];
    for (int c = 0; c < 4; c++) base[c] = rd_tot[c];
    while (n < 16 && cyc < 300) begin
      @(posedge clk);
      #1;
      wready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      ch_frame_start = (cyc == 5) ? fs_mask : 4'b0;
      @(negedge clk);
      if (wvalid && wready) begin
        chk("wdata", wdata, word(ch, exp_n[ch] + n));
        chk("wlast", wlast, n == 15);
        if (n == 0) first = cyc;
        last = cyc;
        n++;
      end
      cyc++;
    end
    chk("beats", n, 16);
    if (!stall) chk("b2b_span", last - first, 15);
    chk("rd_en_cnt", rd_tot[ch] - base[ch], 16);
    for (int c = 0; c < 4; c++) if (c != ch) other += rd_tot[c] - base[c];
    chk("rd_en_other", other, 0);
    exp_n[ch] += 16;
  endtask

  task automatic b_phase(input logic [1:0] resp);
    int cyc = 0;
    @(posedge clk);
    #1 wready = 1'b0;
    ch_frame_start = 4'b0;
    @(negedge clk);
    while (!bready && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("bready", bready, 1'b1);
    bvalid = 1'b1;
    bresp = resp;
    @(posedge clk);
    #1 bvalid = 1'b0;
    bresp = 2'b00;
    @(negedge clk);
    chk("wr_err", wr_err, resp != 2'b00);
  endtask

  task automatic do_burst(input int ch, input logic [27:0] addr, input bit stall, input logic [3:0] fs_mask, input logic [1:0] resp);
    aw_phase(addr, ch_trans_id[4*ch +: 4]);
    w_phase(ch, stall, fs_mask);
    b_phase(resp);
  endtask

  task automatic pulse_rst();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    ch_ready = 4'b0;
    ch_frame_start = 4'b0;
    ch_trans_id = 16'h0200;
    awready = 1'b0;
    wready = 1'b0;
    bvalid = 1'b0;
    bresp = 2'b00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_awvalid", awvalid, 1'b0);
    chk("rst_awaddr", awaddr, 28'h0);
    chk("rst_awid", awid, 4'h0);
    chk("rst_awlen", awlen, 8'd15);
    chk("rst_wstrb", wstrb, 32'hFFFF_FFFF);
    chk("rst_wvalid", wvalid, 1'b0);
    chk("rst_wlast", wlast, 1'b0);
    chk("rst_wdata", wdata, 256'h0);
    chk("rst_rd_en", ch_rd_en, 4'b0);
    chk("rst_bready", bready, 1'b0);
    chk("rst_wr_err", wr_err, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    ch_ready = 4'b0100;
    do_burst(2, 28'h040000, 1'b0, 4'b0, 2'b00);
    do_burst(2, 28'h040200, 1'b1, 4'b0, 2'b00);
    ch_ready = 4'b0;
    ch_trans_id = 16'h9C5A;
    ch_ready = 4'b1000;
    do_burst(3, 28'h060000, 1'b0, 4'b0, 2'b10);
    @(negedge clk);
    chk("wr_err_one_cycle", wr_err, 1'b0);
    do_burst(3, 28'h060200, 1'b1, 4'b0, 2'b00);
    ch_ready = 4'b0;
    pulse_rst();
    ch_ready = 4'b1111;
    do_burst(0, 28'h000000, 1'b0, 4'b0, 2'b00);
    do_burst(1, 28'h020000, 1'b0, 4'b0, 2'b00);
    do_burst(2, 28'h040000, 1'b0, 4'b0, 2'b00);
    do_burst(3, 28'h060000, 1'b0, 4'b0, 2'b00);
    do_burst(0, 28'h000200, 1'b0, 4'b0, 2'b00);
    ch_ready = 4'b0;
    pulse_rst();
    ch_ready = 4'b0100;
    do_burst(2, 28'h040000, 1'b0, 4'b0, 2'b00);
    ch_ready = 4'b0010;
    for (int i = 0; i < 225; i++) do_burst(1, 28'h020000 + 28'(i * 512), 1'b0, 4'b0, 2'b00);
    do_burst(1, 28'h020000, 1'b0, 4'b0, 2'b00);
    do_burst(1, 28'h020200, 1'b0, 4'b0110, 2'b00);
    do_burst(1, 28'h020000, 1'b0, 4'b0, 2'b00);
    ch_ready = 4'b0100;
    do_burst(2, 28'h040000, 1'b0, 4'b0, 2'b00);
    aw_phase(28'h040200, ch_trans_id[11:8]);
    wready = 1'b1;
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_awvalid", awvalid, 1'b0);
    chk("mid_rst_wvalid", wvalid, 1'b0);
    chk("mid_rst_wlast", wlast, 1'b0);
    chk("mid_rst_wdata", wdata, 256'h0);
    chk("mid_rst_rd_en", ch_rd_en, 4'b0);
    chk("mid_rst_bready", bready, 1'b0);
    chk("mid_rst_awaddr", awaddr, 28'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    wready = 1'b0;
    exp_n[2] = fifo_cnt[2];
    ch_ready = 4'b1111;
    do_burst(0, 28'h000000, 1'b0, 4'b0, 2'b00);
    ch_ready = 4'b0;
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
